// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: request/ack memory port feeding a small prefetch queue
// whose head drives the IF/ID stage; a taken jump flushes queued and in-flight words.
module fetch_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] jump_target,
    input  logic        jump_flg,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] address,
    output logic        valid
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    state_t           r_state;
    state_t           w_state_n;
    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W-1:0] w_head_n;
    logic [PTR_W-1:0] w_tail_n;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_n;
    logic [CNT_W-1:0] w_after_pop;
    logic [XLEN-1:0]  r_fetch_pc;
    logic [XLEN-1:0]  w_fetch_pc_n;
    logic [XLEN-1:0]  r_addr;
    logic [XLEN-1:0]  w_addr_n;
    logic [XLEN-1:0]  r_instruction;
    logic [XLEN-1:0]  r_address;
    logic             r_req;
    logic             r_discard;
    logic             w_discard_n;
    logic             r_valid;
    logic             w_push;
    logic             w_pop;
    entry_t           w_head_entry_n;

    // Next-state: redirect wins over everything; otherwise pop/push/issue.
    always_comb begin
        w_state_n      = r_state;
        w_fetch_pc_n   = r_fetch_pc;
        w_addr_n       = r_addr;
        w_discard_n    = r_discard;
        w_head_n       = r_head;
        w_tail_n       = r_tail;
        w_count_n      = r_count;
        w_after_pop    = r_count;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_head_entry_n = '0;

        if (jump_flg) begin
            w_fetch_pc_n = jump_target;
            w_head_n     = '0;
            w_tail_n     = '0;
            w_count_n    = '0;
            if (r_state == S_WAIT) begin
                if (imem_ack) begin
                    w_state_n   = S_IDLE;
                    w_discard_n = 1'b0;
                end else begin
                    w_discard_n = 1'b1;
                end
            end
        end else begin
            w_pop       = r_valid && !stall;
            w_push      = (r_state == S_WAIT) && imem_ack && !r_discard;
            w_after_pop = r_count - CNT_W'(w_pop);
            w_count_n   = w_after_pop + CNT_W'(w_push);
            w_head_n    = r_head + PTR_W'(w_pop);
            w_tail_n    = r_tail + PTR_W'(w_push);

            case (r_state)
                S_IDLE: begin
                    // The outstanding slot is reserved at issue, so a push never overflows.
                    if (w_after_pop < CNT_W'(DEPTH)) begin
                        w_state_n    = S_WAIT;
                        w_addr_n     = r_fetch_pc;
                        w_fetch_pc_n = r_fetch_pc + 32'd4;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        w_state_n   = S_IDLE;
                        w_discard_n = 1'b0;
                    end
                end
                default: w_state_n = S_IDLE;
            endcase

            if (w_count_n != '0) begin
                if (w_after_pop == '0) begin
                    w_head_entry_n = {r_addr, imem_rdata};
                end else begin
                    w_head_entry_n = r_mem[w_head_n];
                end
            end
        end
    end

    // Control state and registered head outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_req         <= 1'b0;
            r_addr        <= RESET_PC;
            r_fetch_pc    <= RESET_PC;
            r_discard     <= 1'b0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_valid       <= 1'b0;
            r_instruction <= '0;
            r_address     <= '0;
        end else begin
            r_state       <= w_state_n;
            r_req         <= (w_state_n == S_WAIT);
            r_addr        <= w_addr_n;
            r_fetch_pc    <= w_fetch_pc_n;
            r_discard     <= w_discard_n;
            r_head        <= w_head_n;
            r_tail        <= w_tail_n;
            r_count       <= w_count_n;
            r_valid       <= (w_count_n != '0);
            r_instruction <= w_head_entry_n.instr;
            r_address     <= w_head_entry_n.pc;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_tail] <= {r_addr, imem_rdata};
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instruction = r_instruction;
    assign address     = r_address;
    assign valid       = r_valid;

endmodule
